writeback_demux: RTL
====================

WRITEBACK_DEMUX -- requirements
Module: writeback_demux

Interface
REQ-001 Parameter: WIDTH, 8, datapath width of ALU result, registers and memory data.
REQ-002 Port: clk  input  1  single clock; all state changes on rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: alu_out  input  WIDTH  ALU result to be written back.
REQ-005 Port: alu_c  input  1  ALU carry-out accompanying alu_out.
REQ-006 Port: s  input  2  destination select: 00 register A, 01 register B, 10 memory, 11 discard (flags only).
REQ-007 Port: wr_en  input  1  write-back request, sampled on rising edge.
REQ-008 Port: addr_in  input  WIDTH  memory address used when s=10.
REQ-009 Port: reg_a  output  WIDTH  register A contents (feeds operand-A selection).
REQ-010 Port: reg_b  output  WIDTH  register B contents (feeds operand-A selection).
REQ-011 Port: mem_data  output  WIDTH  memory write data.
REQ-012 Port: mem_addr  output  WIDTH  memory write address.
REQ-013 Port: mem_valid  output  1  memory write request, held until accepted.
REQ-014 Port: mem_ready  input  1  memory accepts write on an edge where mem_valid=1 and mem_ready=1.
REQ-015 Port: busy  output  1  high while a memory write is outstanding.
REQ-016 Port: flags  output  3  {Z, N, C} of the last accepted write-back.

Function
REQ-017 Two-state FSM: IDLE, MEM_WAIT; busy SHALL equal (state==MEM_WAIT).
REQ-018 IDLE, wr_en=1, s=00: reg_a SHALL load alu_out at that edge; state stays IDLE.
REQ-019 IDLE, wr_en=1, s=01: reg_b SHALL load alu_out at that edge; state stays IDLE.
REQ-020 IDLE, wr_en=1, s=10: mem_data<=alu_out, mem_addr<=addr_in, mem_valid<=1, state<=MEM_WAIT at that edge.
REQ-021 IDLE, wr_en=1, s=11: no register or memory update; only flags update.
REQ-022 Every accepted request (wr_en=1 in IDLE) SHALL update flags at the same edge: Z=(alu_out==0), N=alu_out[WIDTH-1], C=alu_c.
REQ-023 MEM_WAIT: mem_valid, mem_data, mem_addr SHALL hold stable until the accepting edge.
REQ-024 MEM_WAIT with mem_ready=1 at an edge: mem_valid<=0, state<=IDLE; minimum write latency 2 edges from request to IDLE.
REQ-025 mem_ready SHALL be ignored in IDLE, including the request edge itself.
REQ-026 wr_en=1 in MEM_WAIT SHALL be dropped: no register, flag or memory update; controller stalls on busy.
REQ-027 reg_a, reg_b SHALL hold value when not written; no write-through of alu_out same cycle.
REQ-028 Writes of value 0 are legal; Z SHALL set, N clear.

Reset
REQ-029 rst_n low SHALL immediately force: state=IDLE, reg_a=0, reg_b=0, mem_data=0, mem_addr=0, mem_valid=0, busy=0, flags=3'b000.
REQ-030 Reset during MEM_WAIT SHALL abandon the outstanding write; no retry after release.
REQ-031 First request SHALL be accepted at the first rising edge after rst_n deasserts.

Structure
REQ-032 Shared package SHALL hold the destination-select constants (DEST_A=00, DEST_B=01, DEST_MEM=10, DEST_NONE=11), FSM state encoding and flag bit indices, also used by the operand-select logic.
REQ-033 One sub-module is natural: flag_gen (combinational Z/N/C from alu_out, alu_c); remainder inline.

Verification
REQ-034 Reset, then wr_en=1,s=00,alu_out=8'h3C -> next edge reg_a=8'h3C, reg_b=0, flags=000.
REQ-035 wr_en=1,s=01,alu_out=8'h80,alu_c=1 -> reg_b=8'h80, flags Z=0,N=1,C=1; reg_a unchanged.
REQ-036 wr_en=1,s=10,alu_out=8'h55,addr_in=8'h10, mem_ready low 3 cycles then high -> mem_valid/busy high 4 cycles, mem_data=8'h55, mem_addr=8'h10 stable, then clear.
REQ-037 During REQ-036 wait, pulse wr_en,s=00,alu_out=8'hFF -> reg_a and flags unchanged.
REQ-038 wr_en=1,s=11,alu_out=0 -> reg_a, reg_b, mem outputs unchanged; flags Z=1,N=0.
REQ-039 Assert rst_n low mid MEM_WAIT (async, between edges) -> mem_valid, busy, registers 0 immediately; after release, mem_ready=1 causes no activity.

Source files
------------

// File: rtl/writeback_demux_pkg.sv
// Shared constants for the write-back path: destination selects, controller
// state encoding and flag bit positions (also used by operand-select logic).
package writeback_demux_pkg;

    localparam logic [1:0] DEST_A    = 2'b00;
    localparam logic [1:0] DEST_B    = 2'b01;
    localparam logic [1:0] DEST_MEM  = 2'b10;
    localparam logic [1:0] DEST_NONE = 2'b11;

    localparam logic [0:0] ST_IDLE     = 1'b0;
    localparam logic [0:0] ST_MEM_WAIT = 1'b1;

    localparam int FLAG_W = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_N = 1;
    localparam int FLAG_C = 0;

    typedef logic [FLAG_W-1:0] flags_t;

endpackage

// File: rtl/writeback_demux_if.sv
// Memory write port: data/address qualified by a valid/ready handshake.
interface writeback_demux_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] mem_data;
    logic [WIDTH-1:0] mem_addr;
    logic             mem_valid;
    logic             mem_ready;

    modport master (
        output mem_data,
        output mem_addr,
        output mem_valid,
        input  mem_ready
    );

    modport slave (
        input  mem_data,
        input  mem_addr,
        input  mem_valid,
        output mem_ready
    );
endinterface

// File: rtl/writeback_demux_flag_gen.sv
// Combinational {Z, N, C} flags for an ALU result.
module writeback_demux_flag_gen
    import writeback_demux_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_c,
    output flags_t           flags_next
);
    always_comb begin
        flags_next         = '0;
        flags_next[FLAG_Z] = (alu_out == '0);
        flags_next[FLAG_N] = alu_out[WIDTH-1];
        flags_next[FLAG_C] = alu_c;
    end
endmodule

// File: rtl/writeback_demux.sv
// Routes an ALU result to register A, register B or a handshaked memory write,
// recording flags for every accepted request; stalls while a write is pending.
module writeback_demux
    import writeback_demux_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [WIDTH-1:0]     alu_out,
    input  logic                 alu_c,
    input  logic [1:0]           s,
    input  logic                 wr_en,
    input  logic [WIDTH-1:0]     addr_in,
    output logic [WIDTH-1:0]     reg_a,
    output logic [WIDTH-1:0]     reg_b,
    output logic                 busy,
    output logic [FLAG_W-1:0]    flags,
    writeback_demux_if.master    mem
);
    logic [0:0]       state_reg;
    logic [WIDTH-1:0] reg_a_reg;
    logic [WIDTH-1:0] reg_b_reg;
    logic [WIDTH-1:0] mem_data_reg;
    logic [WIDTH-1:0] mem_addr_reg;
    logic             mem_valid_reg;
    flags_t           flags_reg;
    flags_t           flags_next;

    writeback_demux_flag_gen #(
        .WIDTH(WIDTH)
    ) u_flag_gen (
        .alu_out    (alu_out),
        .alu_c      (alu_c),
        .flags_next (flags_next)
    );

    // Requests are only taken in IDLE; mem_ready matters only in MEM_WAIT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            reg_a_reg     <= '0;
            reg_b_reg     <= '0;
            mem_data_reg  <= '0;
            mem_addr_reg  <= '0;
            mem_valid_reg <= 1'b0;
            flags_reg     <= '0;
        end else if (state_reg == ST_IDLE) begin
            if (wr_en) begin
                flags_reg <= flags_next;
                case (s)
                    DEST_A:    reg_a_reg <= alu_out;
                    DEST_B:    reg_b_reg <= alu_out;
                    DEST_MEM: begin
                        mem_data_reg  <= alu_out;
                        mem_addr_reg  <= addr_in;
                        mem_valid_reg <= 1'b1;
                        state_reg     <= ST_MEM_WAIT;
                    end
                    DEST_NONE: ;
                endcase
            end
        end else begin
            if (mem.mem_ready) begin
                mem_valid_reg <= 1'b0;
                state_reg     <= ST_IDLE;
            end
        end
    end

    assign reg_a         = reg_a_reg;
    assign reg_b         = reg_b_reg;
    assign flags         = flags_reg;
    assign busy          = (state_reg == ST_MEM_WAIT);
    assign mem.mem_data  = mem_data_reg;
    assign mem.mem_addr  = mem_addr_reg;
    assign mem.mem_valid = mem_valid_reg;
endmodule
